fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised successor to the single-register fetch stage: generates the PC, issues requests to a synchronous instruction memory, and buffers returned instructions with their PC and PC+4 in a DEPTH-entry prefetch FIFO, so fetch keeps running while decode stalls. The block sits between the PC/imem boundary and the F/D pipeline register. It presents a valid/ready handshake to decode. Branch/JAL and JALR redirects from execute flush the buffer and discard any in-flight response.

## Interface
- DATA_WIDTH, 32, instruction and PC width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0, PC fetched first after reset.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- redirect_i  input  1  execute-stage redirect (branch taken / jump).
- jalr_i  input  1  with redirect_i, target is alu_result_i & ~1, else pc_target_i.
- pc_target_i  input  DATA_WIDTH  branch/JAL target.
- alu_result_i  input  DATA_WIDTH  JALR target before LSB clear.
- imem_req_o  output  1  request strobe; memory always accepts.
- imem_addr_o  output  DATA_WIDTH  request address (= current PC).
- imem_rdata_i  input  DATA_WIDTH  read data, valid exactly one cycle after imem_req_o.
- valid_o  output  1  FIFO head holds an instruction.
- ready_i  input  1  decode accepts head this cycle (~StallDecode).
- instr_o  output  DATA_WIDTH  head instruction.
- pc_o  output  DATA_WIDTH  head PC.
- pc_plus4_o  output  DATA_WIDTH  head PC+4.

## Operation
- State: pc_q, FIFO storage {instr, pc} ×DEPTH, rd/wr pointers (log2(DEPTH) bits, natural wrap), count ($clog2(DEPTH)+1 bits), inflight flag (1 bit), kill flag (1 bit).
- Pop: valid_o && ready_i && !redirect_i → rd_ptr++, count--.
- Issue: imem_req_o = !redirect_i && (count + inflight − pop) < DEPTH; imem_addr_o = pc_q. On issue pc_q ← pc_q + 4 (mod 2^DATA_WIDTH); inflight ← 1 with captured PC; else inflight ← 0.
- Response: cycle after issue, if !kill and !redirect_i, push {imem_rdata_i, captured PC} at wr_ptr, count++. Push and pop in same cycle leave count unchanged.
- Credit rule guarantees push never hits a full FIFO; overflow is a design error (assertion).
- Redirect (redirect_i=1): pc_q ← target; count, pointers ← 0; any pop ignored; no issue this cycle; in-flight response of the previous cycle dropped (kill ← inflight; kill cleared next cycle).
- valid_o = (count != 0). When valid_o=0, instr_o/pc_o/pc_plus4_o drive 0.
- pc_plus4_o = head pc + 4, computed combinationally, wraps modulo 2^DATA_WIDTH.
- No alignment checking: only JALR bit 0 is cleared; other bits pass through.

## Timing
- Reset (rst=0, asynchronous): pc_q=RESET_PC, FIFO empty, inflight=0, kill=0; valid_o=0, imem_req_o=0, instr_o/pc_o/pc_plus4_o=0, imem_addr_o=RESET_PC. Reset mid-operation discards all buffered and in-flight data immediately.
- First request in first clock edge cycle after rst deasserts; first instruction valid_o=1 two cycles after its request (req cycle t, data t+1, valid_o t+2).
- Steady state with ready_i=1: one instruction per cycle, PCs consecutive +4.
- Redirect asserted cycle t: req to target at t+1, target instruction on instr_o with valid_o=1 at t+3; valid_o=0 in cycles t+1, t+2.
- Backpressure (ready_i=0): FIFO fills to DEPTH, then imem_req_o=0; head and all outputs held stable. On ready_i rising, issue resumes the same cycle (pop frees credit).
- redirect_i and ready_i together: redirect wins, head not consumed (decode flushes it).
- redirect_i in consecutive cycles: last one wins; earlier target's request never issued.

## Test plan
- Reset release, RESET_PC=0, ready_i=1, imem returns addr>>2 → requests at 0,4,8…; valid_o first high 2 cycles after release; pc_o 0,4,8 one per cycle, pc_plus4_o 4,8,12.
- ready_i=0 for 10 cycles, DEPTH=4 → exactly 4 entries buffered, imem_req_o low after credits exhausted, outputs stable; release → 4 buffered PCs drained in order, no gap or duplicate.
- Redirect with pc_target_i=0x100 while FIFO holds 3 entries and a request is in flight → valid_o=0 for 2 cycles, next pc_o=0x100, no stale PC ever appears.
- JALR redirect, alu_result_i=0x205 → imem_addr_o=0x204, pc_o=0x204, pc_plus4_o=0x208.
- Redirect coincident with pop and full FIFO; back-to-back redirects to 0x40 then 0x80 → only 0x80 fetched, count=0 after each.
- rst asserted asynchronously mid-stream with FIFO full → outputs zero same cycle, imem_req_o=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch FIFO between the instruction memory and decode.
// Requests are credit-limited so a returning response always has a free slot.
module fetch_prefetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_i,
   input  logic                  jalr_i,
   input  logic [DATA_WIDTH-1:0] pc_target_i,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] pc_plus4_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] cap_pc_q, cap_pc_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  inflight_q, inflight_d;
   logic                  kill_q, kill_d;

   logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];

   logic                  head_valid;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [CNT_W:0]        credit_used;
   logic [DATA_WIDTH-1:0] redirect_target;

   assign head_valid = (count_q != '0);
   assign pop        = head_valid && ready_i && !redirect_i;
   assign push       = inflight_q && !kill_q && !redirect_i;

   // Slots already committed: buffered entries plus the response still on its way,
   // minus the slot decode frees this cycle.
   assign credit_used = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

   // Held low while reset is asserted so no request leaks out of a resetting unit.
   assign issue = rst && !redirect_i && (credit_used < (CNT_W+1)'(DEPTH));

   assign redirect_target = jalr_i ? {alu_result_i[DATA_WIDTH-1:1], 1'b0} : pc_target_i;

   always_comb begin
      pc_d       = pc_q;
      cap_pc_d   = cap_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inflight_d = 1'b0;
      kill_d     = 1'b0;

      if (redirect_i) begin
         pc_d     = redirect_target;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         kill_d   = inflight_q;
      end else begin
         if (issue) begin
            pc_d       = pc_q + DATA_WIDTH'(4);
            cap_pc_d   = pc_q;
            inflight_d = 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_PC;
         cap_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         cap_pc_q   <= cap_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

   // Storage needs no reset: nothing is visible unless count_q says it is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata_i;
         pc_mem[wr_ptr_q]    <= cap_pc_q;
      end
   end

   assign imem_req_o  = issue;
   assign imem_addr_o = pc_q;
   assign valid_o     = head_valid;
   assign instr_o     = head_valid ? instr_mem[rd_ptr_q] : '0;
   assign pc_o        = head_valid ? pc_mem[rd_ptr_q] : '0;
   assign pc_plus4_o  = head_valid ? (pc_mem[rd_ptr_q] + DATA_WIDTH'(4)) : '0;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      (push && !pop) |-> (count_q < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: expected PC streams are queued when a
// fetch stream starts (reset release / redirect) and compared as decode accepts.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_i, jalr_i, ready_i;
   logic [31:0] pc_target_i, alu_result_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i = '0;
   logic        valid_o;
   logic [31:0] instr_o, pc_o, pc_plus4_o;

   int          n_pass = 0;
   int          n_total = 0;
   int          req_cnt = 0;
   int          acc_cnt = 0;
   int          a0;
   logic        saw_40 = 1'b0;
   logic        found;
   logic [31:0] hold_pc, hold_instr;
   logic [31:0] sb_q[$];

   fetch_prefetch_unit #(
      .DATA_WIDTH(32),
      .DEPTH     (4),
      .RESET_PC  (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect_i  (redirect_i),
      .jalr_i      (jalr_i),
      .pc_target_i (pc_target_i),
      .alu_result_i(alu_result_i),
      .imem_req_o  (imem_req_o),
      .imem_addr_o (imem_addr_o),
      .imem_rdata_i(imem_rdata_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .instr_o     (instr_o),
      .pc_o        (pc_o),
      .pc_plus4_o  (pc_plus4_o)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: word content is the word index.
   always_ff @(posedge clk) begin
      if (imem_req_o) imem_rdata_i <= imem_addr_o >> 2;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic push_stream(input logic [31:0] first);
      sb_q.delete();
      for (int i = 0; i < 64; i++) sb_q.push_back(first + 32'(4 * i));
   endtask

   task automatic redirect_to(input logic j, input logic [31:0] tgt, input logic [31:0] alu);
      redirect_i   = 1'b1;
      jalr_i       = j;
      pc_target_i  = tgt;
      alu_result_i = alu;
      push_stream(j ? (alu & ~32'h1) : tgt);
   endtask

   // Observe the current cycle (inputs settled), then advance to just after the next edge.
   task automatic tick();
      logic [31:0] exp;
      #1;
      if (rst && imem_req_o) begin
         req_cnt++;
         if (imem_addr_o == 32'h40) saw_40 = 1'b1;
      end
      if (rst && valid_o && ready_i && !redirect_i) begin
         acc_cnt++;
         if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
         end else begin
            exp = sb_q.pop_front();
            $display("accept pc=%h instr=%h pc4=%h", pc_o, instr_o, pc_plus4_o);
            chk("pc", pc_o, exp);
            chk("instr", instr_o, exp >> 2);
            chk("pc_plus4", pc_plus4_o, exp + 32'd4);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; jalr_i = 1'b0;
      pc_target_i = '0; alu_result_i = '0;
      repeat (3) tick();
      #1;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_pc4", pc_plus4_o, 32'd0);
      chk("rst_addr", imem_addr_o, 32'd0);

      // Release: request at once, first valid two cycles later, then one per cycle.
      rst = 1'b1;
      push_stream(32'h0);
      #1;
      chk("rel_req", 32'(imem_req_o), 32'd1);
      chk("rel_addr", imem_addr_o, 32'd0);
      chk("rel_valid_c0", 32'(valid_o), 32'd0);
      tick();
      chk("rel_valid_c1", 32'(valid_o), 32'd0);
      tick();
      chk("rel_valid_c2", 32'(valid_o), 32'd1);
      a0 = acc_cnt;
      repeat (8) tick();
      chk("steady_rate", 32'(acc_cnt - a0), 32'd8);

      // Backpressure: fill to DEPTH, hold outputs, then drain in order.
      ready_i = 1'b0;
      #1;
      hold_pc = pc_o;
      hold_instr = instr_o;
      repeat (10) begin
         chk("hold_pc", pc_o, hold_pc);
         chk("hold_instr", instr_o, hold_instr);
         tick();
      end
      #1;
      chk("bp_req_low", 32'(imem_req_o), 32'd0);
      chk("bp_buffered", 32'(req_cnt - acc_cnt), 32'd4);
      chk("bp_valid", 32'(valid_o), 32'd1);
      ready_i = 1'b1;
      #1;
      chk("bp_resume_req", 32'(imem_req_o), 32'd1);
      repeat (8) tick();

      // Redirect with 3 buffered and one in flight.
      redirect_to(1'b0, 32'h100, 32'h0);
      #1;
      chk("redir_req_low", 32'(imem_req_o), 32'd0);
      tick();
      redirect_i = 1'b0;
      #1;
      chk("redir_valid_t1", 32'(valid_o), 32'd0);
      chk("redir_req_t1", 32'(imem_req_o), 32'd1);
      chk("redir_addr_t1", imem_addr_o, 32'h100);
      tick();
      chk("redir_valid_t2", 32'(valid_o), 32'd0);
      tick();
      chk("redir_valid_t3", 32'(valid_o), 32'd1);
      chk("redir_pc_t3", pc_o, 32'h100);
      repeat (6) tick();

      // JALR clears only bit 0.
      redirect_to(1'b1, 32'h0, 32'h205);
      tick();
      redirect_i = 1'b0; jalr_i = 1'b0;
      #1;
      chk("jalr_addr", imem_addr_o, 32'h204);
      tick();
      tick();
      chk("jalr_valid", 32'(valid_o), 32'd1);
      chk("jalr_pc", pc_o, 32'h204);
      chk("jalr_pc4", pc_plus4_o, 32'h208);
      repeat (4) tick();

      // PC wrap at the top of the address space.
      redirect_to(1'b0, 32'hFFFF_FFF8, 32'h0);
      tick();
      redirect_i = 1'b0;
      repeat (2) tick();
      chk("wrap_pc0", pc_o, 32'hFFFF_FFF8);
      tick();
      chk("wrap_pc1", pc_o, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus4_o, 32'h0);
      repeat (3) tick();

      // Full FIFO, redirect coincident with ready, then back-to-back redirect.
      ready_i = 1'b0;
      repeat (8) tick();
      ready_i = 1'b1;
      saw_40 = 1'b0;
      redirect_to(1'b0, 32'h40, 32'h0);
      #1;
      chk("b2b_full_valid", 32'(valid_o), 32'd1);
      chk("b2b_req0", 32'(imem_req_o), 32'd0);
      tick();
      redirect_to(1'b0, 32'h80, 32'h0);
      #1;
      chk("b2b_empty1", 32'(valid_o), 32'd0);
      chk("b2b_req1", 32'(imem_req_o), 32'd0);
      tick();
      redirect_i = 1'b0;
      #1;
      chk("b2b_empty2", 32'(valid_o), 32'd0);
      chk("b2b_req2", 32'(imem_req_o), 32'd1);
      chk("b2b_addr", imem_addr_o, 32'h80);
      tick();
      tick();
      chk("b2b_valid", 32'(valid_o), 32'd1);
      chk("b2b_pc", pc_o, 32'h80);
      repeat (4) tick();
      chk("b2b_no_0x40", 32'(saw_40), 32'd0);

      // Asynchronous reset mid-stream with a full FIFO.
      ready_i = 1'b0;
      repeat (8) tick();
      #2;
      chk("arst_pre_valid", 32'(valid_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_instr", instr_o, 32'd0);
      chk("arst_pc", pc_o, 32'd0);
      chk("arst_pc4", pc_plus4_o, 32'd0);
      chk("arst_req", 32'(imem_req_o), 32'd0);
      chk("arst_addr", imem_addr_o, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      push_stream(32'h0);
      #1;
      chk("arst_rel_req", 32'(imem_req_o), 32'd1);
      chk("arst_rel_addr", imem_addr_o, 32'd0);
      ready_i = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         #1;
         if (valid_o) found = 1'b1;
         else tick();
      end
      chk("arst_restart_valid", 32'(found), 32'd1);
      chk("arst_restart_pc", pc_o, 32'd0);
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
